// File: rtl/alu32_checker.sv
// Golden-model checker for alu32: compares each sampled vector and counts pass/err/illegal (first-error capture under ALU32_CHECK_FIRSTERR_EN).
// Latency: verdict is combinational on the sampling cycle; counters and flags update on the next rising edge.
// Backpressure: none; every valid vector in RUN is consumed, and in_valid is ignored in IDLE/HALT.
module alu32_checker #(
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [31:0]      in_A,
    input  logic [31:0]      in_B,
    input  logic [2:0]       in_control,
    input  logic [31:0]      dut_out,
    input  logic             dut_overflow,
    input  logic             dut_zero,
    input  logic             dut_negative,
`ifdef ALU32_CHECK_FIRSTERR_EN
    output logic             first_err_valid,
    output logic [31:0]      first_err_A,
    output logic [31:0]      first_err_B,
    output logic [2:0]       first_err_control,
    output logic [31:0]      first_err_out,
`endif
    output logic             busy,
    output logic             halted,
    output logic             err_flag,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t      state;
    logic [31:0] sum, diff, exp_out;
    logic        exp_ovf, arith, legal, mismatch, sample;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign sum  = in_A + in_B;
    assign diff = in_A - in_B;

    always_comb begin
        exp_out = '0;
        exp_ovf = 1'b0;
        arith   = 1'b0;
        legal   = 1'b1;
        case (in_control)
            3'd2: begin
                exp_out = sum;
                arith   = 1'b1;
                exp_ovf = (in_A[31] == in_B[31]) && (sum[31] != in_A[31]);
            end
            3'd3: begin
                exp_out = diff;
                arith   = 1'b1;
                exp_ovf = (in_A[31] != in_B[31]) && (diff[31] != in_A[31]);
            end
            3'd4:    exp_out = in_A & in_B;
            3'd5:    exp_out = in_A | in_B;
            3'd6:    exp_out = ~(in_A | in_B);
            3'd7:    exp_out = in_A ^ in_B;
            default: legal   = 1'b0;
        endcase
    end

    // Overflow is only meaningful for ADD/SUB, so logic ops never fail on it.
    assign mismatch = (dut_out != exp_out) || (dut_zero != (exp_out == 32'd0)) ||
                      (dut_negative != exp_out[31]) || (arith && (dut_overflow != exp_ovf));

    // A vector arriving with start is dropped: the clear takes priority.
    assign sample = (state == RUN) && in_valid && !start;

    assign busy   = (state == RUN);
    assign halted = (state == HALT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            err_flag          <= 1'b0;
            pass_count        <= '0;
            err_count         <= '0;
            illegal_count     <= '0;
`ifdef ALU32_CHECK_FIRSTERR_EN
            first_err_valid   <= 1'b0;
            first_err_A       <= '0;
            first_err_B       <= '0;
            first_err_control <= '0;
            first_err_out     <= '0;
`endif
        end else if (start) begin
            state             <= RUN;
            err_flag          <= 1'b0;
            pass_count        <= '0;
            err_count         <= '0;
            illegal_count     <= '0;
`ifdef ALU32_CHECK_FIRSTERR_EN
            first_err_valid   <= 1'b0;
            first_err_A       <= '0;
            first_err_B       <= '0;
            first_err_control <= '0;
            first_err_out     <= '0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (stop)
                        state <= IDLE;
                    if (sample) begin
                        if (!legal) begin
                            illegal_count <= sat_inc(illegal_count);
                        end else if (mismatch) begin
                            err_count <= sat_inc(err_count);
                            err_flag  <= 1'b1;
                            if (STOP_ON_ERR && !stop)
                                state <= HALT;
`ifdef ALU32_CHECK_FIRSTERR_EN
                            if (!first_err_valid) begin
                                first_err_valid   <= 1'b1;
                                first_err_A       <= in_A;
                                first_err_B       <= in_B;
                                first_err_control <= in_control;
                                first_err_out     <= dut_out;
                            end
`endif
                        end else begin
                            pass_count <= sat_inc(pass_count);
                        end
                    end
                end
                HALT: if (stop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_checker.sv
// Directed-vector bench for alu32_checker: three instances (default, STOP_ON_ERR=1, CNT_W=2) share one stimulus bus.
module tb_alu32_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0, in_valid = 1'b0;
    logic [31:0] in_A = '0, in_B = '0, dut_out = '0;
    logic [2:0]  in_control = '0;
    logic        dut_overflow = 1'b0, dut_zero = 1'b0, dut_negative = 1'b0;

    logic        busy0, halted0, errf0, busy1, halted1, errf1, busy2, halted2, errf2;
    logic [15:0] pass0, err0, ill0, pass1, err1, ill1;
    logic [1:0]  pass2, err2, ill2;
`ifdef ALU32_CHECK_FIRSTERR_EN
    logic        fev0, fev1, fev2;
    logic [31:0] fea0, feb0, feo0, fea1, feb1, feo1, fea2, feb2, feo2;
    logic [2:0]  fec0, fec1, fec2;
`endif

    always #5 clock = ~clock;

`define CHK_PORTS(B, H, F, P, E, I) \
        .clock(clock), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid), \
        .in_A(in_A), .in_B(in_B), .in_control(in_control), .dut_out(dut_out), \
        .dut_overflow(dut_overflow), .dut_zero(dut_zero), .dut_negative(dut_negative), \
        .busy(B), .halted(H), .err_flag(F), .pass_count(P), .err_count(E), .illegal_count(I)

    alu32_checker #(.CNT_W(16), .STOP_ON_ERR(1'b0)) d0 (
`ifdef ALU32_CHECK_FIRSTERR_EN
        .first_err_valid(fev0), .first_err_A(fea0), .first_err_B(feb0),
        .first_err_control(fec0), .first_err_out(feo0),
`endif
        `CHK_PORTS(busy0, halted0, errf0, pass0, err0, ill0));

    alu32_checker #(.CNT_W(16), .STOP_ON_ERR(1'b1)) d1 (
`ifdef ALU32_CHECK_FIRSTERR_EN
        .first_err_valid(fev1), .first_err_A(fea1), .first_err_B(feb1),
        .first_err_control(fec1), .first_err_out(feo1),
`endif
        `CHK_PORTS(busy1, halted1, errf1, pass1, err1, ill1));

    alu32_checker #(.CNT_W(2), .STOP_ON_ERR(1'b0)) d2 (
`ifdef ALU32_CHECK_FIRSTERR_EN
        .first_err_valid(fev2), .first_err_A(fea2), .first_err_B(feb2),
        .first_err_control(fec2), .first_err_out(feo2),
`endif
        `CHK_PORTS(busy2, halted2, errf2, pass2, err2, ill2));

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] e;
        logic [15:0] i;
        logic        f;
        logic        b;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0;
    logic [15:0] e_pass = 0, e_err = 0, e_ill = 0;
    logic        e_errf = 0, e_run = 0;

    localparam int PASS = 0, ERR = 1, ILL = 2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one vector (optionally with start) and push the expected state of d0 after the edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                        input logic [31:0] o, input logic ov, input logic z, input logic n,
                        input int vd, input logic st = 1'b0);
        exp_t x;
        @(negedge clock);
        in_A = a; in_B = b; in_control = c; dut_out = o;
        dut_overflow = ov; dut_zero = z; dut_negative = n;
        in_valid = 1'b1; start = st; stop = 1'b0;
        if (st) begin
            e_pass = 0; e_err = 0; e_ill = 0; e_errf = 0; e_run = 1;
        end else if (e_run) begin
            case (vd)
                PASS: e_pass++;
                ERR: begin e_err++; e_errf = 1; end
                default: e_ill++;
            endcase
        end
        x.p = e_pass; x.e = e_err; x.i = e_ill; x.f = e_errf; x.b = e_run;
        sb.push_back(x);
    endtask

    task automatic pulse(input logic st, input logic sp);
        @(negedge clock);
        in_valid = 1'b0; start = st; stop = sp;
        if (st) begin
            e_pass = 0; e_err = 0; e_ill = 0; e_errf = 0; e_run = 1;
        end else if (sp) begin
            e_run = 0;
        end
        if (st || sp) begin
            @(negedge clock);
            start = 1'b0; stop = 1'b0;
        end
    endtask

    // Monitor: any cycle that presented a valid vector yields a d0 result half a cycle later.
    initial begin
        logic v;
        exp_t x;
        forever begin
            @(posedge clock);
            v = in_valid && !reset;
            @(negedge clock);
            if (v) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    x = sb.pop_front();
                    chk("d0_pass", 32'(pass0), 32'(x.p));
                    chk("d0_err", 32'(err0), 32'(x.e));
                    chk("d0_illegal", 32'(ill0), 32'(x.i));
                    chk("d0_err_flag", 32'(errf0), 32'(x.f));
                    chk("d0_busy", 32'(busy0), 32'(x.b));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cycles;
        #12;
        chk("rst_pass", 32'(pass0), 0);
        chk("rst_flags", {busy0, halted0, errf0, busy1, halted1, errf1}, 0);
        chk("rst_err_ill", {err0, ill0}, 0);
        @(negedge clock);
        reset = 1'b0;

        send(32'd8, 32'd4, 3'd2, 32'd12, 0, 0, 0, PASS);              // IDLE: ignored
        pulse(1'b1, 1'b0);
        chk("start_busy", {busy0, busy1, busy2}, 3'b111);

        send(32'd8, 32'd4, 3'd2, 32'd12, 0, 0, 0, PASS);
        send(32'd2, 32'd5, 3'd3, 32'hFFFF_FFFD, 0, 0, 1, PASS);
        send(32'd2, 32'd5, 3'd3, 32'd3, 0, 0, 0, ERR);                  // d1 halts here
        send(32'd255, 32'hFFFF_FFF2, 3'd3, 32'd269, 0, 0, 0, PASS);
        send(32'h7FFF_FFFF, 32'd1, 3'd2, 32'h8000_0000, 1, 0, 1, PASS);
        send(32'h1234_5678, 32'd9, 3'd0, 32'd0, 0, 1, 0, ILL);
        send(32'd1, 32'd1, 3'd1, 32'h5555_5555, 1, 0, 0, ILL);
        send(32'hF0F0_0000, 32'hFF00_FF00, 3'd4, 32'hF000_0000, 0, 0, 1, PASS);
        send(32'h0F, 32'hF0, 3'd5, 32'hFF, 0, 0, 0, PASS);
        send(32'd0, 32'd0, 3'd6, 32'hFFFF_FFFF, 0, 0, 1, PASS);
        send(32'd5, 32'd5, 3'd7, 32'd0, 0, 1, 0, PASS);
        send(32'd1, 32'd1, 3'd4, 32'd1, 1, 0, 0, PASS);                 // ovf ignored for AND
        send(32'd1, 32'd1, 3'd2, 32'd2, 1, 0, 0, ERR);                  // bogus ovf on ADD
        send(32'h8000_0000, 32'd1, 3'd3, 32'h7FFF_FFFF, 1, 0, 0, PASS);
        send(32'd3, 32'd3, 3'd7, 32'd0, 0, 0, 0, ERR);                  // zero flag wrong
        pulse(1'b0, 1'b0);

        chk("d1_halted", {busy1, halted1, errf1}, 3'b011);
        chk("d1_pass", 32'(pass1), 2);
        chk("d1_err", 32'(err1), 1);
        chk("d1_illegal", 32'(ill1), 0);
        chk("d2_sat", {pass2, err2, ill2}, {2'd3, 2'd3, 2'd2});
`ifdef ALU32_CHECK_FIRSTERR_EN
        chk("d1_fe_valid", 32'(fev1), 1);
        chk("d1_fe_A", fea1, 32'd2);
        chk("d1_fe_B", feb1, 32'd5);
        chk("d1_fe_ctl", 32'(fec1), 3);
        chk("d1_fe_out", feo1, 32'd3);
        chk("d0_fe_out", feo0, 32'd3);
`endif

        // start with a vector on the same cycle: cleared, vector dropped; d1 leaves HALT
        send(32'd8, 32'd4, 3'd2, 32'd12, 0, 0, 0, PASS, 1'b1);
        pulse(1'b0, 1'b0);
        chk("d1_restart", {busy1, halted1, errf1}, 3'b100);
        chk("d1_restart_cnt", {pass1, err1}, 0);

        send(32'd1, 32'd2, 3'd2, 32'd3, 0, 0, 0, PASS);
        pulse(1'b0, 1'b1);
        chk("stop_idle", {busy0, halted0}, 0);
        send(32'd1, 32'd2, 3'd2, 32'd9, 0, 0, 0, ERR);                  // IDLE: ignored
        pulse(1'b1, 1'b1);                                              // start wins
        chk("start_beats_stop", {busy0, busy1, busy2}, 3'b111);

        for (int k = 0; k < 5; k++)
            send(32'(k), 32'd10, 3'd2, 32'(k + 10), 0, 0, 0, PASS);
        pulse(1'b0, 1'b0);
        chk("d2_pass_sat", 32'(pass2), 3);
        chk("d0_pass5", 32'(pass0), 5);

        #2 reset = 1'b1;
        e_pass = 0; e_err = 0; e_ill = 0; e_errf = 0; e_run = 0;
        #1;
        chk("midreset_d0", {busy0, halted0, errf0, pass0, err0, ill0}, 0);
        chk("midreset_d2", {busy2, pass2}, 0);
        @(negedge clock);
        reset = 1'b0;
        send(32'd1, 32'd1, 3'd2, 32'd2, 0, 0, 0, PASS);                 // IDLE after reset
        pulse(1'b0, 1'b0);

        wait_cycles = 0;
        while (sb.size() != 0 && wait_cycles < 20) begin
            @(negedge clock);
            wait_cycles++;
        end
        chk("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
